// File: rtl/abuf_drain.sv
// abuf_drain: drains PE-array accumulation buffers into a valid/ready stream.
// Ports: clk/rst, start/grp_cnt/depth job control, busy/done status,
//   abuf_rd_addr/rd_sel/abuf_rd_data array read side,
//   out_data/out_grp/out_addr/out_last/out_valid/out_ready result stream.
module abuf_drain #(
    parameter int PE_NUM     = 32,
    parameter int BUF_DEPTH  = 256,
    parameter int RES_W      = 32,
    parameter int BATCH      = 4,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int GW = $clog2(PE_NUM / 4),
    localparam int AW = $clog2(BUF_DEPTH),
    localparam int DW = 4 * BATCH * RES_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [GW:0]   grp_cnt,
    input  logic [AW:0]   depth,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] abuf_rd_addr,
    output logic [GW-1:0] rd_sel,
    input  logic [DW-1:0] abuf_rd_data,
    output logic [DW-1:0] out_data,
    output logic [GW-1:0] out_grp,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          v;
        logic [GW-1:0] g;
        logic [AW-1:0] a;
        logic          l;
    } tag_t;

    typedef struct packed {
        logic [GW-1:0] g;
        logic [AW-1:0] a;
        logic          l;
        logic [DW-1:0] d;
    } ent_t;

    state_t        state, nstate;
    logic [GW:0]   gcnt_q, g_lim;
    logic [AW:0]   dep_q, d_lim;
    logic [GW-1:0] grp_q, igrp_q;
    logic [AW-1:0] addr_q;
    logic          zdone_q;
    // Stage 0 shadows abuf_rd_addr; stage RD_LAT lines up with abuf_rd_data.
    tag_t          sr [RD_LAT+1];
    ent_t          mem [FIFO_DEPTH];
    ent_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, infl;
    logic          start_ok, start_nil, iss, push, pop, full, credit;
    logic          last_a, last_g, is_last;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        start_nil = (state == IDLE) && start && (grp_cnt == '0 || depth == '0);
        start_ok  = (state == IDLE) && start && !(grp_cnt == '0 || depth == '0);
        g_lim     = (state == IDLE) ? grp_cnt : gcnt_q;
        d_lim     = (state == IDLE) ? depth : dep_q;
        last_a    = {1'b0, addr_q} == d_lim - (AW+1)'(1);
        last_g    = {1'b0, grp_q} == g_lim - (GW+1)'(1);
        is_last   = last_a && last_g;
        infl      = '0;
        for (int i = 0; i <= RD_LAT; i++)
            infl = infl + CW'(sr[i].v);
        push      = sr[RD_LAT].v;
        pop       = (cnt != '0) && out_ready;
        full      = cnt == CW'(FIFO_DEPTH);
        // A pop this cycle frees its slot for the read issued now.
        credit    = (cnt + infl - CW'(pop)) < CW'(FIFO_DEPTH);
        // The FIFO is empty in IDLE, so the first read needs no credit check.
        iss       = start_ok || (state == ISSUE && credit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start_ok) nstate = is_last ? DRAIN : ISSUE;
            ISSUE:   if (iss && is_last) nstate = DRAIN;
            DRAIN:   if (infl == '0 && cnt == '0) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ISSUE) || (state == DRAIN);
        done = (state == DONE) || zdone_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q       <= '0;
            dep_q        <= '0;
            grp_q        <= '0;
            addr_q       <= '0;
            igrp_q       <= '0;
            abuf_rd_addr <= '0;
            rd_sel       <= '0;
            zdone_q      <= 1'b0;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i <= RD_LAT; i++)
                sr[i] <= '0;
        end else begin
            zdone_q <= start_nil;
            if (start_ok) begin
                gcnt_q <= grp_cnt;
                dep_q  <= depth;
            end
            if (iss) begin
                abuf_rd_addr <= addr_q;
                igrp_q       <= grp_q;
                if (is_last) begin
                    addr_q <= '0;
                    grp_q  <= '0;
                end else if (last_a) begin
                    addr_q <= '0;
                    grp_q  <= grp_q + GW'(1);
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end
            // The array mux is registered, so it needs the group one cycle late.
            rd_sel <= igrp_q;
            sr[0]  <= iss ? {1'b1, grp_q, addr_q, is_last} : '0;
            for (int i = 1; i <= RD_LAT; i++)
                sr[i] <= sr[i-1];
            cnt <= cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {sr[RD_LAT].g, sr[RD_LAT].a, sr[RD_LAT].l, abuf_rd_data};
    end

    always_comb begin
        head      = mem[rd_ptr];
        out_valid = cnt != '0;
        out_data  = out_valid ? head.d : '0;
        out_grp   = out_valid ? head.g : '0;
        out_addr  = out_valid ? head.a : '0;
        out_last  = out_valid ? head.l : 1'b0;
    end

    push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
